// File: rtl/seq_scan_arbiter.sv
// Round-robin scheduler sharing one serial MSB-first pattern-scan engine among N_REQ requesters.
// Each granted word is scanned for overlapping PATTERN occurrences; the count is reported with a done pulse.
module seq_scan_arbiter #(
   parameter int unsigned       N_REQ   = 4,
   parameter int unsigned       WORD_W  = 8,
   parameter int unsigned       PAT_W   = 5,
   parameter logic [PAT_W-1:0]  PATTERN = 5'b10010
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*WORD_W-1:0]     data,
   output logic [N_REQ-1:0]            grant,
   output logic                        busy,
   output logic                        ser_bit,
   output logic                        hit,
   output logic                        done,
   output logic [$clog2(N_REQ)-1:0]    done_id,
   output logic [3:0]                  match_cnt
);

   localparam int unsigned IDW = $clog2(N_REQ);
   localparam int unsigned SW  = $clog2(PAT_W + 1);
   localparam int unsigned CW  = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

   state_t            state, state_nx;
   logic [IDW-1:0]    ptr, cur, pick, idx;
   logic              found;
   logic [WORD_W-1:0] sh;
   logic [PAT_W-2:0]  win;
   logic [PAT_W-1:0]  w;
   logic [SW-1:0]     seen;
   logic [3:0]        cnt;
   logic [CW-1:0]     bitcnt;
   logic              match;
   logic              last_bit;

   // First set request at or above ptr, wrapping; power-of-two N_REQ makes the wrap free.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = ptr + IDW'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign w        = {win, sh[WORD_W-1]};
   assign match    = (w == PATTERN) && (seen >= SW'(PAT_W - 1));
   assign last_bit = (bitcnt == CW'(WORD_W - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (found)    state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = REPORT;
         REPORT:                state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         cur       <= '0;
         sh        <= '0;
         win       <= '0;
         seen      <= '0;
         cnt       <= '0;
         bitcnt    <= '0;
         hit       <= 1'b0;
         done_id   <= '0;
         match_cnt <= '0;
      end else begin
         hit <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  sh     <= data[pick*WORD_W +: WORD_W];
                  cur    <= pick;
                  ptr    <= pick + IDW'(1);
                  win    <= '0;
                  seen   <= '0;
                  cnt    <= '0;
                  bitcnt <= '0;
               end
            end
            SHIFT: begin
               win    <= w[PAT_W-2:0];
               sh     <= {sh[WORD_W-2:0], 1'b0};
               bitcnt <= bitcnt + CW'(1);
               if (seen != SW'(PAT_W)) seen <= seen + SW'(1);
               if (match) begin
                  cnt <= cnt + 4'd1;
                  hit <= 1'b1;
               end
               // The final bit's match must be folded into the reported count directly.
               if (last_bit) begin
                  match_cnt <= cnt + {3'b000, match};
                  done_id   <= cur;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == REPORT);
   assign ser_bit = (state == SHIFT) ? sh[WORD_W-1] : 1'b0;
   assign grant   = busy ? (N_REQ'(1) << cur) : '0;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: directed plan plus randomized jobs,
// checked against a bit-list pattern counter and a round-robin pointer model.
module tb_seq_scan_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int P = 5;
   localparam logic [P-1:0] PAT = 5'b10010;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   data;
   logic [N-1:0]     grant;
   logic             busy, ser_bit, hit, done;
   logic [1:0]       done_id;
   logic [3:0]       match_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int mptr     = 0;

   seq_scan_arbiter #(.N_REQ(N), .WORD_W(W), .PAT_W(P), .PATTERN(PAT)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant), .busy(busy),
      .ser_bit(ser_bit), .hit(hit), .done(done), .done_id(done_id), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++)
         if (r[(mptr + i) % N]) return (mptr + i) % N;
      return 0;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, " grant"}, 32'(grant), 0);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " ser_bit"}, 32'(ser_bit), 0);
      check({tag, " hit"}, 32'(hit), 0);
      check({tag, " done"}, 32'(done), 0);
      check({tag, " done_id"}, 32'(done_id), 0);
      check({tag, " match_cnt"}, 32'(match_cnt), 0);
   endtask

   // Entered and left at a negedge with the DUT in IDLE; the entry negedge is cycle 0.
   task automatic job(input logic [N-1:0] r, input logic [N*W-1:0] d, input bit drop);
      int k, cnt;
      logic [W-1:0] wd;
      bit bits[W];
      bit exp_hit[W+3];
      bit m;
      k    = model_pick(r);
      mptr = (k + 1) % N;
      wd   = d[k*W +: W];
      for (int i = 0; i < W; i++) bits[i] = wd[W-1-i];
      for (int c = 0; c < W + 3; c++) exp_hit[c] = 1'b0;
      cnt = 0;
      for (int e = P - 1; e < W; e++) begin
         m = 1'b1;
         for (int p = 0; p < P; p++)
            if (bits[e-P+1+p] != PAT[P-1-p]) m = 1'b0;
         if (m) begin
            cnt++;
            exp_hit[e+2] = 1'b1;
         end
      end
      req  = r;
      data = d;
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge clk);
         check($sformatf("grant c%0d", c), 32'(grant), 32'(1) << k);
         check($sformatf("busy c%0d", c), 32'(busy), 1);
         check($sformatf("hit c%0d", c), 32'(hit), 32'(exp_hit[c]));
         check($sformatf("done c%0d", c), 32'(done), 32'(c == W + 1));
         if (c <= W) check($sformatf("ser_bit c%0d", c), 32'(ser_bit), 32'(bits[c-1]));
         if (c == W + 1) begin
            check("done_id", 32'(done_id), 32'(k));
            check("match_cnt", 32'(match_cnt), 32'(cnt));
         end
         if (drop && c == 3) begin
            req  = '0;
            data = ~d;
         end
      end
      @(negedge clk);
      check("idle grant", 32'(grant), 0);
      check("idle busy", 32'(busy), 0);
      check("idle done", 32'(done), 0);
      check("idle hit", 32'(hit), 0);
      check("held done_id", 32'(done_id), 32'(k));
      check("held match_cnt", 32'(match_cnt), 32'(cnt));
   endtask

   initial begin
      logic [N*W-1:0] d;
      rst  = 1'b1;
      req  = '0;
      data = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      job(4'b0001, {24'h0, 8'b10010010}, 1'b0);
      job(4'b0001, {24'h0, 8'h00}, 1'b0);
      job(4'b0001, {24'h0, 8'b10010000}, 1'b0);

      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      mptr = 0;
      check("ptr reset grant", 32'(grant), 0);
      for (int j = 0; j < 5; j++) job(4'b1111, {$urandom, $urandom} , 1'b0);

      job(4'b1000, 32'h92_12_49_90, 1'b0);
      job(4'b1001, 32'h92_12_49_90, 1'b0);
      job(4'b1000, 32'h92_12_49_90, 1'b0);
      job(4'b1000, 32'h92_12_49_90, 1'b0);

      job(4'b0100, 32'h00_92_00_00, 1'b1);

      d    = {$urandom, $urandom};
      req  = 4'b0110;
      data = d;
      repeat (4) @(negedge clk);
      check("pre-reset busy", 32'(busy), 1);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("mid-job reset");
      for (int c = 0; c < W + 2; c++) begin
         @(negedge clk);
         check($sformatf("aborted done c%0d", c), 32'(done), 0);
      end
      mptr = 0;
      job(4'b1111, {$urandom, $urandom}, 1'b0);

      for (int j = 0; j < 25; j++) begin
         d = {$urandom, $urandom};
         if (j % 3 == 0) d[($urandom % N)*W +: W] = 8'b10010010;
         job(4'($urandom_range(1, 15)), d, ($urandom % 4) == 0);
         req = '0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_scan_arbiter.md
# seq_scan_arbiter

Round-robin scheduler that shares a single serial pattern-scan engine among `N_REQ` requesters. Each granted requester's `WORD_W`-bit word is shifted MSB-first through a Moore-style window matcher. The number of (overlapping) occurrences of `PATTERN` in that word is reported with a one-cycle `done` pulse. It sits between the per-channel capture logic and the status/reporting block, and is the sole owner of the scan engine.

## Interface
- `N_REQ`, 4, number of requesters; power of two, 2..8.
- `WORD_W`, 8, bits per job; `PAT_W` <= `WORD_W` <= 15.
- `PAT_W`, 5, pattern length in bits.
- `PATTERN`, 5'b10010, pattern to count; its MSB is the first bit received.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `data`  in  N_REQ*WORD_W  word of requester k at `[k*WORD_W +: WORD_W]`; sampled only at the grant edge.
- `grant`  out  N_REQ  one-hot; high from the first SHIFT cycle through the REPORT cycle.
- `busy`  out  1  high in SHIFT and REPORT.
- `ser_bit`  out  1  bit currently fed to the matcher (debug).
- `hit`  out  1  one-cycle pulse, cycle after a bit completes a match.
- `done`  out  1  one-cycle pulse in REPORT.
- `done_id`  out  log2(N_REQ)  index of the finished requester; held until the next `done`.
- `match_cnt`  out  4  match count for the finished job; held until the next `done`.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- **IDLE**
  - If `req` is nonzero, pick the first set bit searching upward from `ptr`, with wrap-around.
  - At the edge: latch that requester's word into the shift register, set `grant[k]`, clear the window, `seen` and `cnt`, set `ptr` to (k+1) mod N_REQ, and go to SHIFT.
  - If `req` is zero, stay in IDLE.
- **SHIFT** (exactly `WORD_W` cycles)
  - `ser_bit` is the shift-register MSB.
  - Each edge: `w = {window[PAT_W-2:0], ser_bit}`; `window <= w`; `seen` increments, saturating at `PAT_W`.
  - If `w == PATTERN` and `seen+1 >= PAT_W`, then `cnt` increments and `hit` is set for one cycle.
  - The shift register shifts left by one.
  - After the `WORD_W`-th bit, go to REPORT, register `cnt` into `match_cnt` and k into `done_id`, and set `done`.
- **REPORT** (1 cycle)
  - `done`=1, `busy`=1, `grant` still held.
  - Next state is always IDLE; `grant` goes to 0 there.
- Window history never carries across jobs; matches are counted only within one word.
- Overlapping matches count separately (10010010 gives 2).
- Changes to `req` or `data` during SHIFT/REPORT are ignored; the current job always completes.
- A requester that still has `req` high in IDLE is re-arbitrated normally. Its priority is now lowest because of the `ptr` update.
- Reset values:
  - `grant`=0, `busy`=0, `ser_bit`=0, `hit`=0, `done`=0, `done_id`=0, `match_cnt`=0.
  - `ptr`=0, state=IDLE.
- Reset mid-job aborts the job: no `done`, and `match_cnt`/`done_id` return to 0.

## Timing
- `req` high in IDLE at cycle 0 gives `grant`/`busy` high at cycle 1.
- `ser_bit` presents word bit `WORD_W-1-i` in cycle 1+i.
- `done` is high at cycle `WORD_W`+1 (cycle 9 with defaults).
- IDLE follows at cycle `WORD_W`+2. The earliest next grant is cycle `WORD_W`+3, so back-to-back service costs `WORD_W`+2 cycles per job.
- `hit` for the bit fed in cycle c is visible in cycle c+1; this can coincide with `done`.
- `match_cnt` is updated in the same cycle `done` rises.
- Maximum count with defaults is 2; the 4-bit width covers every legal `WORD_W`.

## Test plan
- **Single job, two matches:** `req`=0001, `data[7:0]`=8'b10010010.
  - `grant`=0001 in cycles 1-9.
  - `hit` pulses in cycles 6 and 9.
  - `done` in cycle 9 with `done_id`=0, `match_cnt`=2.
- **No match and single match:**
  - Word 8'h00 gives `match_cnt`=0 and no `hit`.
  - Word 8'b10010000 gives `match_cnt`=1 with `hit` in cycle 6.
- **Fairness:** `req`=1111 held constant.
  - `done_id` sequence is 0, 1, 2, 3, 0.
  - `done` pulses 10 cycles apart.
- **Pointer wrap:** after serving requester 3, `req`=1001 grants 0 next; `req`=1000 after serving 3 grants 3 again.
- **Mid-job request change:**
  - `req` dropped and `data` changed in cycle 3 of a job: the result still matches the word latched at the grant edge.
- **Reset mid-SHIFT:** `rst`=1 in cycle 4.
  - The next cycle shows all outputs 0 and state IDLE.
  - No `done` for the aborted job.
  - The next `req`=1111 grants requester 0.
